// File: rtl/dmem_access_unit_if.sv
// CPU-side request/response bundle for the data-memory access unit.
interface dmem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Byte/half/word load-store front-end for a word-only data memory.
// Build option DMEM_MISALIGN_TRAP_EN: reject misaligned accesses instead of force-aligning them.
module dmem_access_unit #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_unit_if.slave bus,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_a,
  output logic [31:0]       dm_d,
  input  logic [31:0]       dm_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         merge_q, merge_d;

  logic                req_err;
  logic [ADDR_W+1:0]   req_addr_al;
  logic                misaligned;
  logic                wr_en;
  logic [31:0]         lane;
  logic [31:0]         load_val;
  logic [31:0]         merged;

  // Request legality and the address actually used for the access.
  always_comb begin
    misaligned  = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                  ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_addr_al = bus.req_addr[ADDR_W+1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    req_err     = (bus.req_size == 2'b11) || misaligned;
`else
    req_err     = (bus.req_size == 2'b11);
    if (bus.req_size == 2'b01) req_addr_al[0]   = 1'b0;
    if (bus.req_size == 2'b10) req_addr_al[1:0] = 2'b00;
`endif
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    lane   = dm_q >> {addr_q[1:0], 3'b000};
    merged = dm_q;
    case (size_q)
      2'b00: begin
        load_val = sgn_q ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = sgn_q ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: load_val = dm_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          wdata_d = bus.req_wdata;
          err_d   = req_err;
          rdata_d = '0;
          // Rejected requests leave the memory address bus where it was.
          if (!req_err) addr_d = req_addr_al;
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = load_val;
          state_d = RESP;
        end else if (size_q == 2'b10) begin
          wr_en   = 1'b1;
          state_d = RESP;
        end else begin
          merge_d = merged;
          state_d = MERGE_WR;
        end
      end
      MERGE_WR: begin
        wr_en   = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) & err_q;
  assign bus.resp_rdata = rdata_q;

  assign dm_we = rst & wr_en;
  assign dm_a  = addr_q[ADDR_W+1:2];
  assign dm_d  = (state_q == MERGE_WR) ? merge_q : wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit against a 64-word async-read memory model.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        dm_we;
  logic [5:0]  dm_a;
  logic [31:0] dm_d;
  logic [31:0] dm_q;
  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.ADDR_W(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .dm_we(dm_we),
    .dm_a (dm_a),
    .dm_d (dm_d),
    .dm_q (dm_q)
  );

  assign dm_q = mem[dm_a];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hFFFF_FFFF;
    end else if (dm_we) begin
      mem[dm_a] <= dm_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int we_cnt, output int we_cyc, output logic rdy_ok);
    int guard;
    @(negedge clk);
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; we_cnt = 0; we_cyc = 0; rdata = '0; err = 1'b0;
    rdy_ok = (guard < 20);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dm_we) begin
        we_cnt++;
        we_cyc = c;
      end
      if (bus.req_ready) rdy_ok = 1'b0;
      if (bus.resp_valid) begin
        lat   = c;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    if (!bus.req_ready || bus.resp_valid) rdy_ok = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input int exp_we_cnt, input int exp_we_cyc);
    logic [31:0] rdata;
    logic        err;
    int          lat, we_cnt, we_cyc;
    logic        rdy_ok;
    run_req(we, size, sgn, addr, wdata, rdata, err, lat, we_cnt, we_cyc, rdy_ok);
    chk({tag, ".lat"},    32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"},  rdata, exp_rdata);
    chk({tag, ".err"},    32'(err), 32'(exp_err));
    chk({tag, ".we_cnt"}, 32'(we_cnt), 32'(exp_we_cnt));
    chk({tag, ".we_cyc"}, 32'(we_cyc), 32'(exp_we_cyc));
    chk({tag, ".ready"},  32'(rdy_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic resp_seen;
    logic we_seen;
    rst            = 1'b0;
    mem_clr        = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    chk("rst.req_ready",  32'(bus.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_err",   32'(bus.resp_err), 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst.dm_we",      32'(dm_we), 32'd0);
    chk("rst.dm_a",       32'(dm_a), 32'd0);
    chk("rst.dm_d",       dm_d, 32'h0);
    rst = 1'b1;

    //  tag         we    size   sgn   addr   wdata            exp_rdata      err  lat we wcyc
    txn("ldb_s_05",  1'b0, 2'b00, 1'b1, 32'h05, 32'h0,          32'hFFFF_FFFF, 1'b0, 2, 0, 0);
    txn("ldb_u_05",  1'b0, 2'b00, 1'b0, 32'h05, 32'h0,          32'h0000_00FF, 1'b0, 2, 0, 0);
    txn("stb_06",    1'b1, 2'b00, 1'b0, 32'h06, 32'h12,         32'h0,         1'b0, 3, 1, 2);
    txn("ldw_04",    1'b0, 2'b10, 1'b0, 32'h04, 32'h0,          32'hFF12_FFFF, 1'b0, 2, 0, 0);
    txn("sth_0a",    1'b1, 2'b01, 1'b0, 32'h0A, 32'hABCD,       32'h0,         1'b0, 3, 1, 2);
    txn("ldh_u_0a",  1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,          32'h0000_ABCD, 1'b0, 2, 0, 0);
    txn("ldh_s_0a",  1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,          32'hFFFF_ABCD, 1'b0, 2, 0, 0);
    txn("ldw_08",    1'b0, 2'b10, 1'b0, 32'h08, 32'h0,          32'hABCD_FFFF, 1'b0, 2, 0, 0);
    txn("stw_10",    1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF,  32'h0,         1'b0, 2, 1, 1);
    txn("ldw_10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0,          32'hDEAD_BEEF, 1'b0, 2, 0, 0);
    txn("ldb_u_11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0,          32'h0000_00BE, 1'b0, 2, 0, 0);
    txn("ldb_s_10",  1'b0, 2'b00, 1'b1, 32'h10, 32'h0,          32'hFFFF_FFEF, 1'b0, 2, 0, 0);
    txn("ldh_s_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0,          32'hFFFF_DEAD, 1'b0, 2, 0, 0);
    txn("stb_03",    1'b1, 2'b00, 1'b0, 32'h03, 32'hAAAA_AA5C,  32'h0,         1'b0, 3, 1, 2);
    txn("ldw_00",    1'b0, 2'b10, 1'b0, 32'h00, 32'h0,          32'h5CFF_FFFF, 1'b0, 2, 0, 0);
    txn("sz3_ld",    1'b0, 2'b11, 1'b0, 32'h30, 32'h0,          32'h0,         1'b1, 1, 0, 0);
    txn("sz3_st",    1'b1, 2'b11, 1'b0, 32'h30, 32'h1234_5678,  32'h0,         1'b1, 1, 0, 0);
    txn("ldw_30",    1'b0, 2'b10, 1'b0, 32'h30, 32'h0,          32'hFFFF_FFFF, 1'b0, 2, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("ldw_13",    1'b0, 2'b10, 1'b0, 32'h13, 32'h0,          32'h0,         1'b1, 1, 0, 0);
    txn("sth_0d",    1'b1, 2'b01, 1'b0, 32'h0D, 32'h1234,       32'h0,         1'b1, 1, 0, 0);
    txn("ldw_0c",    1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,          32'hFFFF_FFFF, 1'b0, 2, 0, 0);
`else
    txn("ldw_13",    1'b0, 2'b10, 1'b0, 32'h13, 32'h0,          32'hDEAD_BEEF, 1'b0, 2, 0, 0);
    txn("sth_0d",    1'b1, 2'b01, 1'b0, 32'h0D, 32'h1234,       32'h0,         1'b0, 3, 1, 2);
    txn("ldw_0c",    1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,          32'hFFFF_1234, 1'b0, 2, 0, 0);
`endif

    // Half store to 0x20 interrupted by reset during its write cycle.
    resp_seen = 1'b0;
    we_seen   = 1'b0;
    @(negedge clk);
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b01;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h5555;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    if (dm_we) we_seen = 1'b1;
    if (bus.resp_valid) resp_seen = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dm_we) we_seen = 1'b1;
      if (bus.resp_valid) resp_seen = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dm_we) we_seen = 1'b1;
      if (bus.resp_valid) resp_seen = 1'b1;
    end
    chk("midrst.no_we",     32'(we_seen), 32'd0);
    chk("midrst.no_resp",   32'(resp_seen), 32'd0);
    chk("midrst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst.resp_rdata", bus.resp_rdata, 32'h0);
    chk("midrst.dm_a",      32'(dm_a), 32'd0);
    chk("midrst.dm_d",      dm_d, 32'h0);
    txn("ldw_20",    1'b0, 2'b10, 1'b0, 32'h20, 32'h0,          32'hFFFF_FFFF, 1'b0, 2, 0, 0);
    txn("ldw_04b",   1'b0, 2'b10, 1'b0, 32'h04, 32'h0,          32'hFF12_FFFF, 1'b0, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
